el2_dec_gpr_wb_arb: RTL and testbench
=====================================

Name: el2_dec_gpr_wb_arb

Overview:
- Write-back scheduler in front of the 3-write-port integer GPR file.
- Write port 0 is dedicated to the in-order pipe.
- Write ports 1 and 2 are shared round-robin among N_REQ secondary requesters: non-blocking load return, divider, debug abstract command, spare.
- Guarantees that no two ports write the same GPR in the same cycle. Outputs are registered and drive the GPR file's wen*/waddr*/wd* directly.

Parameters:
- N_REQ, 4, number of secondary requesters (2..8).
- STALL_CNT_W, 16, width of per-requester stall counters (optional feature only).

Ports:
- clk  in  1  core clock.
- rst_l  in  1  asynchronous active-low reset.
- scan_mode  in  1  passed to flop enables.
- pipe_wen  in  1  pipe write-back valid; never stalled.
- pipe_waddr  in  5  pipe destination.
- pipe_wd  in  32  pipe data.
- req_valid  in  N_REQ  secondary request valid.
- req_waddr  in  N_REQ x 5  secondary destination.
- req_wd  in  N_REQ x 32  secondary data.
- req_ready  out  N_REQ  accept (grant) this cycle.
- wen0/wen1/wen2  out  1  GPR write enables.
- waddr0/waddr1/waddr2  out  5  GPR write addresses.
- wd0/wd1/wd2  out  32  GPR write data.
- arb_busy  out  1  any req_valid not accepted this cycle.

Behaviour:
- Reset: all outputs 0; RR pointer = 0; stall counters 0.
- Reset asserted mid-request: in-flight registered write dropped. Requesters must re-present after reset.
- Handshake: transfer when req_valid[i] & req_ready[i].
  - req_ready is combinational from the current cycle's valids, addresses, pipe_wen/pipe_waddr and the pointer.
  - Requesters must hold valid, waddr and wd stable until accepted; valid must not depend on ready.
- Latency: a pipe write or accepted request in cycle N appears on its write port in cycle N+1 for exactly one cycle.
- Eligibility of request i: valid and waddr not equal to pipe_waddr when pipe_wen=1 and pipe_waddr!=0. Otherwise it is deferred; the pipe always wins.
- Selection: scan eligible requests starting at the pointer, wrapping at N_REQ.
  - First winner goes to port 1, second to port 2.
  - A candidate whose waddr equals the first winner's nonzero waddr is skipped, so at most 2 grants per cycle.
- Pointer: advances to (last granted index + 1) mod N_REQ; unchanged if no grant.
- x0 handling:
  - A request to waddr=0 is accepted normally and consumes a grant slot, but its port's wen is forced 0.
  - pipe_waddr=0 yields wen0=0.
  - x0 never causes a collision deferral.
- Unused ports drive wen=0, waddr=0, wd=0.
- Same-register ordering between pipe and secondary writes is the upstream scoreboard's job. This block guarantees only same-cycle exclusivity.
- Assertion (RV_ASSERT_ON): no two registered wen* with equal nonzero waddr; req_ready never without req_valid.

Optional Feature:
- Macro RV_GPR_WB_ARB_STATS_EN.
- Defined:
  - adds output stall_cnt (N_REQ x STALL_CNT_W);
  - counter i increments each cycle req_valid[i] & ~req_ready[i], saturates at all-ones, and is cleared only by reset.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - typedef gpr_wb_req_t {waddr[4:0], wd[31:0]};
  - constant GPR_WB_NPORTS = 3.
- Sub-module el2_dec_wb_rr_pick:
  - rotating find-first with exclusion mask;
  - parameterised N_REQ;
  - instantiated twice (port 1 pick; port 2 pick with first winner and same-address requesters masked).
- Output registers use the standard enable flop.

Test Plan:
- Reset release, no traffic -> all wen* = 0 and req_ready = 0 for 5 cycles.
- pipe x5 = 0xA5A5_0001, req0 x5, req1 x7, pointer 0 -> ready = 0b0010; next cycle wen0 x5 and wen1 x7 = req1 data. req0 accepted the following cycle on port 1.
- All 4 requesters valid to x1..x4 continuously, pointer 0 -> grants {0,1}, {2,3}, {0,1}, ... on ports 1/2; each write visible exactly one cycle later.
- req1 and req2 both to x9, pointer 1 -> only req1 ready; req2 granted next cycle; no two wen* with x9 in the same cycle.
- req3 to x0 alone -> req_ready[3] = 1, wen1 stays 0, pointer becomes 0.
- rst_l pulled low for 1 cycle while req0 pending and a write registered -> outputs 0 immediately, pointer 0; (STATS_EN) stall_cnt cleared, then counts 3 after 3 blocked cycles.

Source files
------------

// File: rtl/el2_dec_gpr_wb_arb_pkg.sv
// ============================================================================
// el2_dec_gpr_wb_arb_pkg : shared types for the GPR write-back scheduler
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package el2_dec_gpr_wb_arb_pkg;

  localparam int GPR_WB_NPORTS = 3;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wd;
  } gpr_wb_req_t;

  // A write to x0 never reaches the register file.
  function automatic logic gpr_wb_live(input logic wen, input logic [4:0] waddr);
    return wen & (waddr != 5'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/el2_dec_wb_rr_pick.sv
// ============================================================================
// el2_dec_wb_rr_pick : rotating find-first over requests, minus an exclusion mask
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module el2_dec_wb_rr_pick
  import el2_dec_gpr_wb_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_excl,
  input  logic [PTR_W-1:0] i_ptr,
  output logic             o_vld,
  output logic [PTR_W-1:0] o_idx
);

  logic [N_REQ-1:0] w_cand;
  logic [PTR_W-1:0] w_j;
  int               j;

  // Scanning from the far end lets the candidate nearest the pointer win last.
  always_comb begin
    w_cand = i_req & ~i_excl;
    o_vld  = 1'b0;
    o_idx  = '0;
    j      = 0;
    w_j    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      w_j = PTR_W'(j);
      if (w_cand[w_j]) begin
        o_vld = 1'b1;
        o_idx = w_j;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/el2_dec_gpr_wb_arb.sv
// ============================================================================
// el2_dec_gpr_wb_arb : schedules pipe + N_REQ secondary writes onto 3 GPR ports
// Optional stall counters via RV_GPR_WB_ARB_STATS_EN. Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module el2_dec_gpr_wb_arb
  import el2_dec_gpr_wb_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        scan_mode,
  input  logic                        pipe_wen,
  input  logic [4:0]                  pipe_waddr,
  input  logic [31:0]                 pipe_wd,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][4:0]       req_waddr,
  input  logic [N_REQ-1:0][31:0]      req_wd,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        wen0,
  output logic                        wen1,
  output logic                        wen2,
  output logic [4:0]                  waddr0,
  output logic [4:0]                  waddr1,
  output logic [4:0]                  waddr2,
  output logic [31:0]                 wd0,
  output logic [31:0]                 wd1,
  output logic [31:0]                 wd2,
`ifdef RV_GPR_WB_ARB_STATS_EN
  output logic [N_REQ-1:0][STALL_CNT_W-1:0] stall_cnt,
`endif
  output logic                        arb_busy
);

  localparam int PTR_W = $clog2(N_REQ);

  if ((N_REQ < 2) || (N_REQ > 8) || (STALL_CNT_W < 1)) begin : g_param_check
    $error("el2_dec_gpr_wb_arb: unsupported N_REQ/STALL_CNT_W");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  w_elig, w_excl1, w_excl2, w_grant;
  logic              w_vld1, w_vld2;
  logic [PTR_W-1:0]  w_idx1, w_idx2;
  logic [4:0]        w_win1_addr;

  logic              wen_d  [GPR_WB_NPORTS];
  logic              wen_q  [GPR_WB_NPORTS];
  gpr_wb_req_t       port_d [GPR_WB_NPORTS];
  gpr_wb_req_t       port_q [GPR_WB_NPORTS];

  // The pipe owns its destination this cycle; x0 never blocks anyone.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i] = req_valid[i] &
                  ~(gpr_wb_live(pipe_wen, pipe_waddr) && (req_waddr[i] == pipe_waddr));
    end
  end

  assign w_excl1     = '0;
  assign w_win1_addr = req_waddr[w_idx1];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_excl2[i] = w_vld1 &
                   ((PTR_W'(i) == w_idx1) ||
                    ((w_win1_addr != 5'd0) && (req_waddr[i] == w_win1_addr)));
    end
  end

  el2_dec_wb_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick1 (
    .i_req  (w_elig),
    .i_excl (w_excl1),
    .i_ptr  (ptr_q),
    .o_vld  (w_vld1),
    .o_idx  (w_idx1)
  );

  el2_dec_wb_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick2 (
    .i_req  (w_elig),
    .i_excl (w_excl2),
    .i_ptr  (ptr_q),
    .o_vld  (w_vld2),
    .o_idx  (w_idx2)
  );

  always_comb begin
    w_grant = '0;
    if (w_vld1) w_grant[w_idx1] = 1'b1;
    if (w_vld2) w_grant[w_idx2] = 1'b1;
    ptr_d = ptr_q;
    if (w_vld2)      ptr_d = ptr_inc(w_idx2);
    else if (w_vld1) ptr_d = ptr_inc(w_idx1);
  end

  assign req_ready = rst_l ? w_grant : '0;
  assign arb_busy  = rst_l & (|(req_valid & ~w_grant));

  // A port with wen low always carries zero address and data, x0 grants included.
  always_comb begin
    wen_d[0]  = gpr_wb_live(pipe_wen, pipe_waddr);
    port_d[0] = wen_d[0] ? '{waddr: pipe_waddr, wd: pipe_wd} : '0;
    wen_d[1]  = gpr_wb_live(w_vld1, req_waddr[w_idx1]);
    port_d[1] = wen_d[1] ? '{waddr: req_waddr[w_idx1], wd: req_wd[w_idx1]} : '0;
    wen_d[2]  = gpr_wb_live(w_vld2, req_waddr[w_idx2]);
    port_d[2] = wen_d[2] ? '{waddr: req_waddr[w_idx2], wd: req_wd[w_idx2]} : '0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ptr_q <= '0;
      for (int p = 0; p < GPR_WB_NPORTS; p++) begin
        wen_q[p]  <= 1'b0;
        port_q[p] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int p = 0; p < GPR_WB_NPORTS; p++) begin
        if (wen_d[p] | wen_q[p] | scan_mode) begin
          wen_q[p]  <= wen_d[p];
          port_q[p] <= port_d[p];
        end
      end
    end
  end

  assign wen0   = wen_q[0];
  assign wen1   = wen_q[1];
  assign wen2   = wen_q[2];
  assign waddr0 = port_q[0].waddr;
  assign waddr1 = port_q[1].waddr;
  assign waddr2 = port_q[2].waddr;
  assign wd0    = port_q[0].wd;
  assign wd1    = port_q[1].wd;
  assign wd2    = port_q[2].wd;

`ifdef RV_GPR_WB_ARB_STATS_EN
  logic [N_REQ-1:0][STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stall_cnt_d[i] = stall_cnt_q[i];
      if (req_valid[i] & ~w_grant[i] & ~(&stall_cnt_q[i]))
        stall_cnt_d[i] = stall_cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

`ifdef RV_ASSERT_ON
  a_port_exclusive: assert property (@(posedge clk) disable iff (!rst_l)
    !((wen0 && wen1 && (waddr0 == waddr1) && (waddr0 != 5'd0)) ||
      (wen0 && wen2 && (waddr0 == waddr2) && (waddr0 != 5'd0)) ||
      (wen1 && wen2 && (waddr1 == waddr2) && (waddr1 != 5'd0))));
  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_l)
    ((req_ready & ~req_valid) == '0));
`endif

endmodule

`default_nettype wire

// File: tb/tb_el2_dec_gpr_wb_arb.sv
// ============================================================================
// tb_el2_dec_gpr_wb_arb : directed + random checks against a scan-order model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_el2_dec_gpr_wb_arb;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_l, scan_mode, pipe_wen;
  logic [4:0]          pipe_waddr;
  logic [31:0]         pipe_wd;
  logic [N-1:0]        req_valid;
  logic [N-1:0][4:0]   req_waddr;
  logic [N-1:0][31:0]  req_wd;
  logic [N-1:0]        req_ready;
  logic                wen0, wen1, wen2, arb_busy;
  logic [4:0]          waddr0, waddr1, waddr2;
  logic [31:0]         wd0, wd1, wd2;
`ifdef RV_GPR_WB_ARB_STATS_EN
  logic [N-1:0][15:0]  stall_cnt;
`endif

  int          total = 0;
  int          bad   = 0;
  int          mptr  = 0;
  int unsigned ms [N];

  always #5 clk = ~clk;

  el2_dec_gpr_wb_arb #(.N_REQ(N), .STALL_CNT_W(16)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .scan_mode  (scan_mode),
    .pipe_wen   (pipe_wen),
    .pipe_waddr (pipe_waddr),
    .pipe_wd    (pipe_wd),
    .req_valid  (req_valid),
    .req_waddr  (req_waddr),
    .req_wd     (req_wd),
    .req_ready  (req_ready),
    .wen0       (wen0),
    .wen1       (wen1),
    .wen2       (wen2),
    .waddr0     (waddr0),
    .waddr1     (waddr1),
    .waddr2     (waddr2),
    .wd0        (wd0),
    .wd1        (wd1),
    .wd2        (wd2),
`ifdef RV_GPR_WB_ARB_STATS_EN
    .stall_cnt  (stall_cnt),
`endif
    .arb_busy   (arb_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walk requesters in order from the pointer; pipe collisions are skipped,
  // the second winner may not share the first winner's nonzero register.
  task automatic model_grant(output int w1, output int w2);
    int i;
    w1 = -1;
    w2 = -1;
    for (int k = 0; k < N; k++) begin
      i = (mptr + k) % N;
      if (req_valid[i] !== 1'b1) continue;
      if (pipe_wen && pipe_waddr != 0 && req_waddr[i] == pipe_waddr) continue;
      if (w1 < 0) w1 = i;
      else if (w2 < 0 && !(req_waddr[w1] != 0 && req_waddr[i] == req_waddr[w1])) w2 = i;
    end
  endtask

  task automatic step(input string tag, input bit chk_want, input logic [N-1:0] want);
    int           w1, w2, last;
    logic [N-1:0] g;
    logic [37:0]  e0, e1, e2;
    #1;
    model_grant(w1, w2);
    g = '0;
    if (w1 >= 0) g[w1] = 1'b1;
    if (w2 >= 0) g[w2] = 1'b1;
    check({tag, ".ready"}, 64'(req_ready), 64'(g));
    check({tag, ".busy"}, 64'(arb_busy), 64'(|(req_valid & ~g)));
    if (chk_want) check({tag, ".ready_const"}, 64'(req_ready), 64'(want));
    e0 = (pipe_wen && pipe_waddr != 0) ? {1'b1, pipe_waddr, pipe_wd} : 38'd0;
    e1 = (w1 >= 0 && req_waddr[w1] != 0) ? {1'b1, req_waddr[w1], req_wd[w1]} : 38'd0;
    e2 = (w2 >= 0 && req_waddr[w2] != 0) ? {1'b1, req_waddr[w2], req_wd[w2]} : 38'd0;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && !g[i] && ms[i] < 32'hFFFF) ms[i]++;
    @(posedge clk);
    #1;
    check({tag, ".port0"}, 64'({wen0, waddr0, wd0}), 64'(e0));
    check({tag, ".port1"}, 64'({wen1, waddr1, wd1}), 64'(e1));
    check({tag, ".port2"}, 64'({wen2, waddr2, wd2}), 64'(e2));
`ifdef RV_GPR_WB_ARB_STATS_EN
    for (int i = 0; i < N; i++) check({tag, ".stall"}, 64'(stall_cnt[i]), 64'(ms[i]));
`endif
    last = (w2 >= 0) ? w2 : w1;
    if (last >= 0) mptr = (last + 1) % N;
    req_valid = req_valid & ~g;
  endtask

  initial begin
    rst_l      = 1'b0;
    scan_mode  = 1'b0;
    pipe_wen   = 1'b0;
    pipe_waddr = '0;
    pipe_wd    = '0;
    req_valid  = '0;
    req_waddr  = '0;
    req_wd     = '0;
    for (int i = 0; i < N; i++) ms[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;

    for (int c = 0; c < 5; c++) step("idle", 1'b1, 4'b0000);

    // pipe owns x5, so req1 goes first and req0 follows
    pipe_wen = 1'b1; pipe_waddr = 5'd5; pipe_wd = 32'hA5A5_0001;
    req_valid = 4'b0011;
    req_waddr[0] = 5'd5; req_wd[0] = 32'h1111_1111;
    req_waddr[1] = 5'd7; req_wd[1] = 32'h2222_2222;
    step("pipe_defer", 1'b1, 4'b0010);
    pipe_wen = 1'b0;
    step("req0_late", 1'b1, 4'b0001);

    req_valid = 4'b0110;
    req_waddr[1] = 5'd9; req_wd[1] = 32'h9999_0001;
    req_waddr[2] = 5'd9; req_wd[2] = 32'h9999_0002;
    step("x9_first", 1'b1, 4'b0010);
    step("x9_second", 1'b1, 4'b0100);

    req_valid = 4'b1000;
    req_waddr[3] = 5'd0; req_wd[3] = 32'hDEAD_BEEF;
    step("x0_req", 1'b1, 4'b1000);

    for (int r = 0; r < 4; r++) begin
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) begin
        req_waddr[i] = 5'(i + 1);
        req_wd[i]    = $urandom;
      end
      step("rr_all", 1'b1, (r % 2 == 0) ? 4'b0011 : 4'b1100);
    end

    // registered writes in flight, req0 held off by the pipe, then reset
    req_valid = 4'b0011;
    pipe_wen = 1'b1; pipe_waddr = 5'd1; pipe_wd = 32'h0BAD_F00D;
    req_waddr[0] = 5'd1; req_wd[0] = 32'h0000_00A0;
    req_waddr[1] = 5'd2; req_wd[1] = 32'h0000_00B1;
    step("pre_reset", 1'b1, 4'b0010);
    #1 rst_l = 1'b0;
    #1;
    check("reset.wen", 64'({wen0, wen1, wen2}), 64'd0);
    check("reset.ports", 64'({waddr0, waddr1, waddr2, wd2}), 64'd0);
    check("reset.ready", 64'(req_ready), 64'd0);
    check("reset.busy", 64'(arb_busy), 64'd0);
    mptr = 0;
    for (int i = 0; i < N; i++) ms[i] = 0;
`ifdef RV_GPR_WB_ARB_STATS_EN
    check("reset.stall0", 64'(stall_cnt[0]), 64'd0);
`endif
    @(posedge clk);
    #1 rst_l = 1'b1;
    for (int c = 0; c < 3; c++) step("blocked", 1'b1, 4'b0000);
`ifdef RV_GPR_WB_ARB_STATS_EN
    check("stall3", 64'(stall_cnt[0]), 64'd3);
`endif
    pipe_wen = 1'b0;
    step("unblock", 1'b1, 4'b0001);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_waddr[i] = 5'($urandom_range(0, 7));
          req_wd[i]    = $urandom;
        end
      end
      pipe_wen   = 1'($urandom_range(0, 1));
      pipe_waddr = 5'($urandom_range(0, 7));
      pipe_wd    = $urandom;
      scan_mode  = ($urandom_range(0, 15) == 0);
      step("rand", 1'b0, 4'b0000);
    end

    pipe_wen  = 1'b0;
    scan_mode = 1'b0;
    for (int c = 0; c < 4; c++) step("drain", 1'b0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
